// File: rtl/lz_norm_pkg.sv
// Shared helpers for the leading-zero normalizer: width/stage calculations and the
// sideband record that travels down the shift pipeline next to the data word.
package lz_norm_pkg;

  // Sideband field widths; sized for the widest mantissa/exponent this block supports.
  localparam int unsigned SbLzW  = 16;
  localparam int unsigned SbExpW = 16;

  // Width needed to hold a leading-zero count of 0..size.
  function automatic int unsigned lz_width(input int unsigned size);
    return $clog2(size) + 1;
  endfunction

  // Number of radix-4 shift stages after the count stage.
  function automatic int unsigned stage_num(input int unsigned size);
    return ($clog2(size) + 1) / 2;
  endfunction

  // Accept-to-out_valid latency with no stall.
  function automatic int unsigned norm_latency(input int unsigned size);
    return 1 + stage_num(size);
  endfunction

  typedef struct packed {
    logic              valid;
    logic [SbLzW-1:0]  shamt;
    logic              zero;
    logic [SbExpW-1:0] exp;
    logic              denorm;
  } norm_sb_t;

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero counter built by recursive halving.
// Returns SIZE for an all-zero input.
module lead_zero_count
  import lz_norm_pkg::*;
#(
  parameter int unsigned SIZE = 32,
  parameter int unsigned LZ_W = lz_width(SIZE)
) (
  input  logic [SIZE-1:0] din,
  output logic [LZ_W-1:0] lz
);

  if (SIZE == 1) begin : g_leaf
    assign lz = LZ_W'(~din[0]);
  end else begin : g_split
    localparam int unsigned LoW   = SIZE / 2;
    localparam int unsigned HiW   = SIZE - LoW;
    localparam int unsigned HiLzW = lz_width(HiW);
    localparam int unsigned LoLzW = lz_width(LoW);

    logic [HiLzW-1:0] lz_hi;
    logic [LoLzW-1:0] lz_lo;

    lead_zero_count #(
      .SIZE (HiW),
      .LZ_W (HiLzW)
    ) u_hi (
      .din (din[SIZE-1:LoW]),
      .lz  (lz_hi)
    );

    lead_zero_count #(
      .SIZE (LoW),
      .LZ_W (LoLzW)
    ) u_lo (
      .din (din[LoW-1:0]),
      .lz  (lz_lo)
    );

    // An empty upper half contributes its full width plus the lower half's count.
    always_comb begin
      if (lz_hi == HiLzW'(HiW)) begin
        lz = LZ_W'(HiW) + LZ_W'(lz_lo);
      end else begin
        lz = LZ_W'(lz_hi);
      end
    end
  end

endmodule

// File: rtl/lz_normalizer.sv
// Pipelined leading-zero normalizer: counts leading zeros, then left-shifts the
// mantissa in radix-4 stages so the MSB is set. One global advance enable stalls
// every stage together.
// Optional build macro NORM_EXP_CLAMP_EN: limits the shift to exp_in and reports
// the adjusted exponent and a denormal flag.
module lz_normalizer
  import lz_norm_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned LZ_W  = lz_width(SIZE),
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  dout,
  output logic [LZ_W-1:0]  shamt,
`ifdef NORM_EXP_CLAMP_EN
  input  logic [EXP_W-1:0] exp_in,
  output logic [EXP_W-1:0] exp_out,
  output logic             denorm,
`endif
  output logic             zero
);

  localparam int unsigned StageNum = stage_num(SIZE);

  logic            advance;
  logic [LZ_W-1:0] lz;
  norm_sb_t        sb_d;
  norm_sb_t        sb_q   [StageNum+1];
  logic [SIZE-1:0] data_q [StageNum+1];
  logic [SIZE-1:0] shift_d[StageNum];

  lead_zero_count #(
    .SIZE (SIZE),
    .LZ_W (LZ_W)
  ) u_lzc (
    .din (din),
    .lz  (lz)
  );

  assign out_valid = sb_q[StageNum].valid;
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;

  // Stage-0 sideband: shift amount, zero flag and (optionally) the clamped exponent.
  always_comb begin
    sb_d       = '0;
    sb_d.valid = in_valid;
    sb_d.zero  = (lz == LZ_W'(SIZE));
`ifdef NORM_EXP_CLAMP_EN
    if (32'(lz) > 32'(exp_in)) begin
      sb_d.shamt  = SbLzW'(exp_in);
      sb_d.denorm = ~sb_d.zero;
    end else begin
      sb_d.shamt = SbLzW'(lz);
      sb_d.exp   = SbExpW'(32'(exp_in) - 32'(lz));
    end
    if (sb_d.zero) begin
      sb_d.exp    = '0;
      sb_d.denorm = 1'b0;
    end
`else
    sb_d.shamt = SbLzW'(lz);
    sb_d.exp   = SbExpW'({EXP_W{1'b0}});
`endif
  end

  // Stage k shifts by shamt digit k (radix 4); the last stage takes all remaining bits.
  // Oversized shifts naturally produce zero, so an all-zero word never wraps.
  always_comb begin
    for (int k = 0; k < StageNum; k++) begin
      if (k == StageNum - 1) begin
        shift_d[k] = data_q[k] << ((sb_q[k].shamt >> (2 * k)) << (2 * k));
      end else begin
        shift_d[k] = data_q[k] << (((sb_q[k].shamt >> (2 * k)) & SbLzW'(3)) << (2 * k));
      end
    end
  end

  // Pipeline registers; everything, including valid bits, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= StageNum; i++) begin
        data_q[i] <= '0;
        sb_q[i]   <= '0;
      end
    end else if (advance) begin
      data_q[0] <= din;
      sb_q[0]   <= sb_d;
      for (int k = 0; k < StageNum; k++) begin
        data_q[k+1] <= shift_d[k];
        sb_q[k+1]   <= sb_q[k];
      end
    end
  end

  assign dout  = data_q[StageNum];
  assign shamt = sb_q[StageNum].shamt[LZ_W-1:0];
  assign zero  = sb_q[StageNum].zero;
`ifdef NORM_EXP_CLAMP_EN
  assign exp_out = sb_q[StageNum].exp[EXP_W-1:0];
  assign denorm  = sb_q[StageNum].denorm;
`endif

  // Upper sideband bits are wider than this instance needs.
  logic unused_sb;
  assign unused_sb = ^sb_q[StageNum];

endmodule

// File: tb/tb_lz_normalizer.sv
// Directed bench for lz_normalizer (SIZE=32). Clamp tests are built only when
// NORM_EXP_CLAMP_EN is defined.
module tb_lz_normalizer;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned LZ_W  = 6;
  localparam int unsigned EXP_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] din = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] dout;
  logic [LZ_W-1:0] shamt;
  logic            zero;
`ifdef NORM_EXP_CLAMP_EN
  logic [EXP_W-1:0] exp_in = 8'd255;
  logic [EXP_W-1:0] exp_out;
  logic             denorm;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [38:0] got_q[$];
  int          got_cyc[$];

  always #5 clk = ~clk;

  lz_normalizer #(
    .SIZE  (SIZE),
    .LZ_W  (LZ_W),
    .EXP_W (EXP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .shamt     (shamt),
`ifdef NORM_EXP_CLAMP_EN
    .exp_in    (exp_in),
    .exp_out   (exp_out),
    .denorm    (denorm),
`endif
    .zero      (zero)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record output transfers mid-cycle (they complete on the next rising edge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({zero, shamt, dout});
      got_cyc.push_back(cyc);
    end
  end

  // Reference: {zero, shamt, dout}.
  function automatic logic [38:0] model(input logic [SIZE-1:0] d);
    int lz;
    lz = 0;
    while (lz < SIZE && d[SIZE-1-lz] == 1'b0) lz++;
    if (lz == SIZE) return {1'b1, 6'(SIZE), 32'h0};
    return {1'b0, 6'(lz), d << lz};
  endfunction

  // Send one word into an empty pipe and wait for its result (left on the outputs).
  task automatic run_one(input logic [31:0] d, output int lat, output logic [31:0] o_dout,
                         output logic [5:0] o_shamt, output logic o_zero);
    din = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    o_dout = dout;
    o_shamt = shamt;
    o_zero = zero;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    checks++; if (shamt !== 6'd0) begin errors++; $display("FAIL reset_shamt: got %0d expected 0", shamt); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat; logic [31:0] d; logic [5:0] s; logic z;
    run_one(32'h0000_1234, lat, d, s, z);
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
    checks++; if (d !== 32'h91A0_0000) begin errors++; $display("FAIL single_dout: got %h expected 91a00000", d); end
    checks++; if (s !== 6'd19) begin errors++; $display("FAIL single_shamt: got %0d expected 19", s); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL single_zero: got %b expected 0", z); end
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    logic [31:0] vin [3];
    logic [31:0] vout[3];
    logic [5:0]  vsh [3];
    logic        vz  [3];
    int lat; logic [31:0] d; logic [5:0] s; logic z;
    vin  = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    vout = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vsh  = '{6'd0, 6'd31, 6'd32};
    vz   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_one(vin[i], lat, d, s, z);
      checks++; if (lat !== 4) begin errors++; $display("FAIL boundary_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (d !== vout[i]) begin errors++; $display("FAIL boundary_dout[%0d]: got %h expected %h", i, d, vout[i]); end
      checks++; if (s !== vsh[i]) begin errors++; $display("FAIL boundary_shamt[%0d]: got %0d expected %0d", i, s, vsh[i]); end
      checks++; if (z !== vz[i]) begin errors++; $display("FAIL boundary_zero[%0d]: got %b expected %b", i, z, vz[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[64];
    int n;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) words[i] = $urandom >> $urandom_range(0, 32);
    for (int i = 0; i < 64; i++) begin
      din = words[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 64 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL b2b_count: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== model(words[i])) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, got_q[i], model(words[i])); end
    end
    if (got_cyc.size() >= 64) begin
      checks++; if (got_cyc[63] - got_cyc[0] !== 63) begin errors++; $display("FAIL b2b_consecutive: got span %0d expected 63", got_cyc[63] - got_cyc[0]); end
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] words[64];
    int sent, n;
    logic acc;
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 64; i++) words[i] = $urandom >> $urandom_range(0, 32);
    sent = 0; n = 0;
    while ((sent < 64 || got_q.size() < 64) && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 64);
      if (sent < 64) din = words[sent];
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (in_ready !== out_ready) begin errors++; $display("FAIL rand_in_ready: got %b expected %b", in_ready, out_ready); end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL rand_count: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== model(words[i])) begin errors++; $display("FAIL rand_word[%0d]: got %h expected %h", i, got_q[i], model(words[i])); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w[5];
    logic [38:0] head;
    int n;
    got_q.delete(); got_cyc.delete();
    w = '{32'h0000_0F00, 32'h0001_0000, 32'h4000_0001, 32'h0000_0003, 32'h00AB_CDEF};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = w[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    head = model(w[0]);
    out_ready = 1'b0;
    din = w[4];
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({out_valid, in_ready, dout, shamt} !== {1'b1, 1'b0, head[31:0], head[37:32]}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%b d=%h s=%0d expected v=1 r=0 d=%h s=%0d",
                 c, out_valid, in_ready, dout, shamt, head[31:0], head[37:32]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 5 && n < 30) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== model(w[i])) begin errors++; $display("FAIL stall_word[%0d]: got %h expected %h", i, got_q[i], model(w[i])); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [31:0] d; logic [5:0] s; logic z;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h0000_0100 << i;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale outputs expected 0", seen); end
    run_one(32'h0000_00F0, lat, d, s, z);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    checks++; if (d !== 32'hF000_0000) begin errors++; $display("FAIL rstmid_dout: got %h expected f0000000", d); end
    checks++; if (s !== 6'd24) begin errors++; $display("FAIL rstmid_shamt: got %0d expected 24", s); end
    @(posedge clk); #1;
  endtask

`ifdef NORM_EXP_CLAMP_EN
  task automatic test_clamp();
    int lat; logic [31:0] d; logic [5:0] s; logic z;
    exp_in = 8'd10;
    run_one(32'h0000_00FF, lat, d, s, z);
    checks++; if (s !== 6'd10) begin errors++; $display("FAIL clamp_shamt: got %0d expected 10", s); end
    checks++; if (d !== 32'h0003_FC00) begin errors++; $display("FAIL clamp_dout: got %h expected 0003fc00", d); end
    checks++; if (exp_out !== 8'd0) begin errors++; $display("FAIL clamp_exp_out: got %0d expected 0", exp_out); end
    checks++; if (denorm !== 1'b1) begin errors++; $display("FAIL clamp_denorm: got %b expected 1", denorm); end
    @(posedge clk); #1;
    exp_in = 8'd40;
    run_one(32'h0000_00FF, lat, d, s, z);
    checks++; if (s !== 6'd24) begin errors++; $display("FAIL noclamp_shamt: got %0d expected 24", s); end
    checks++; if (d !== 32'hFF00_0000) begin errors++; $display("FAIL noclamp_dout: got %h expected ff000000", d); end
    checks++; if (exp_out !== 8'd16) begin errors++; $display("FAIL noclamp_exp_out: got %0d expected 16", exp_out); end
    checks++; if (denorm !== 1'b0) begin errors++; $display("FAIL noclamp_denorm: got %b expected 0", denorm); end
    @(posedge clk); #1;
    exp_in = 8'd255;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_random_ready();
    test_stall();
    test_reset_mid();
`ifdef NORM_EXP_CLAMP_EN
    test_clamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
